// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: mode, burst direction and FSM state.
package usr_pkg;

  typedef enum logic [2:0] {
    ModeHold  = 3'b000,
    ModeLoad  = 3'b001,
    ModeShl   = 3'b010,
    ModeShr   = 3'b011,
    ModeRotl  = 3'b100,
    ModeRotr  = 3'b101,
    ModeAshr  = 3'b110,
    ModeClear = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    DirShl  = 2'b00,
    DirShr  = 2'b01,
    DirRotl = 2'b10,
    DirRotr = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  function automatic mode_e dir_to_mode(dir_e d);
    unique case (d)
      DirShl:  return ModeShl;
      DirShr:  return ModeShr;
      DirRotl: return ModeRotl;
      default: return ModeRotr;
    endcase
  endfunction

  // Modes that move bits and therefore redefine which end ser_out watches.
  function automatic logic is_shift_mode(mode_e m);
    return (m == ModeShl) || (m == ModeShr) || (m == ModeRotl) || (m == ModeRotr) ||
           (m == ModeAshr);
  endfunction

  function automatic logic is_left_mode(mode_e m);
    return (m == ModeShl) || (m == ModeRotl);
  endfunction

endpackage

// File: rtl/usr_shift_unit.sv
// Combinational next-value datapath: load, clear, shifts and rotates of the register contents.
module usr_shift_unit
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  mode_e            op,
  input  logic             fill,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    unique case (op)
      ModeHold:  nxt = cur;
      ModeLoad:  nxt = data;
      ModeShl:   nxt = {cur[WIDTH-2:0], fill};
      ModeShr:   nxt = {fill, cur[WIDTH-1:1]};
      ModeRotl:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      ModeRotr:  nxt = {cur[0], cur[WIDTH-1:1]};
      ModeAshr:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      ModeClear: nxt = '0;
      default:   nxt = cur;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with single-cycle modes and a counted burst shift/rotate engine.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     RST_VAL = '0,
  localparam int unsigned         CNTW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             ser_in,
  input  logic             start,
  input  logic [1:0]       dir,
  input  logic [CNTW-1:0]  count,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_e           state_q;
  dir_e             dir_q;
  logic [CNTW-1:0]  rem_q;
  logic [WIDTH-1:0] q_q;
  logic             left_q;
  logic             done_q;

  mode_e            op;
  logic             fill;
  logic [WIDTH-1:0] nxt;
  logic [CNTW-1:0]  count_clamped;
  mode_e            mode_in;

  assign mode_in       = mode_e'(mode);
  assign count_clamped = (count > CNTW'(WIDTH)) ? CNTW'(WIDTH) : count;

  // Burst steps fill with zero; single-cycle shifts use ser_in.
  always_comb begin
    op   = ModeHold;
    fill = ser_in;
    if (state_q == StShift && rem_q != '0) begin
      op   = dir_to_mode(dir_q);
      fill = 1'b0;
    end else if (state_q == StIdle && !start) begin
      op = mode_in;
    end
  end

  usr_shift_unit #(
    .WIDTH (WIDTH)
  ) u_shift_unit (
    .cur  (q_q),
    .op   (op),
    .fill (fill),
    .data (data),
    .nxt  (nxt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      dir_q   <= DirShl;
      rem_q   <= '0;
      q_q     <= RST_VAL;
      left_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (en) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dir_q   <= dir_e'(dir);
            rem_q   <= count_clamped;
            left_q  <= is_left_mode(dir_to_mode(dir_e'(dir)));
            state_q <= StShift;
          end else begin
            q_q <= nxt;
            if (is_shift_mode(mode_in)) begin
              left_q <= is_left_mode(mode_in);
            end
          end
        end
        StShift: begin
          if (rem_q == '0) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            q_q   <= nxt;
            rem_q <= rem_q - CNTW'(1);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign q       = q_q;
  assign ser_out = left_q ? q_q[WIDTH-1] : q_q[0];
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign zero    = (q_q == '0);

endmodule
